// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: data word, RAM status codes and the
// coherence controller state encoding.
package cpu_types_pkg;

  localparam int unsigned CPUS_MAX = 8;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE,
    SNOOP,
    RESP,
    C2C,
    RAMRD,
    RAMWR,
    IFETCH
  } mc_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: the first requester at or after ptr wins,
// wrapping around. Combinational; grant is one-hot.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic                 valid
);

  localparam int unsigned PW = $clog2(N);

  // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!valid && i >= 32'(ptr) && req[PW'(i)]) begin
        grant[PW'(i)] = 1'b1;
        valid         = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!valid && i < 32'(ptr) && req[PW'(i)]) begin
        grant[PW'(i)] = 1'b1;
        valid         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_coherence_ctrl.sv
// Multi-CPU memory controller with round-robin arbitration and optional
// snoopy cache-to-cache transfers (enabled by BUS_COHERENCE_CTRL_SNOOP_EN).
module bus_coherence_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned CPUS   = 4,
  parameter int unsigned RAM_AW = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS-1:0][31:0]  iaddr,
  input  logic [CPUS-1:0][31:0]  daddr,
  input  logic [CPUS-1:0][31:0]  dstore,
  input  logic [CPUS-1:0]        cctrans,
  input  logic [CPUS-1:0]        ccwrite,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS-1:0][31:0]  iload,
  output logic [CPUS-1:0][31:0]  dload,
  output logic [CPUS-1:0]        ccwait,
  output logic [CPUS-1:0]        ccinv,
  output logic [CPUS-1:0][31:0]  ccsnoopaddr,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [RAM_AW-1:0]      ramaddr,
  output logic [31:0]            ramstore,
  input  logic [31:0]            ramload,
  input  logic [1:0]             ramstate
);

  localparam int unsigned GW = $clog2(CPUS);

  mc_state_t     state, state_n;
  logic [GW-1:0] gnt, gnt_n, dptr, dptr_n, iptr, iptr_n;
  logic [CPUS-1:0] dgrant_oh, igrant_oh;
  logic          dvalid, ivalid;
  logic [GW-1:0] didx, iidx;
  logic          go_snoop;
  ramstate_t     ram_st;
  word_t         ram_rdata;

  assign ram_st    = ramstate_t'(ramstate);
  assign ram_rdata = ramload;

  function automatic logic [GW-1:0] ptr_inc(input logic [GW-1:0] p);
    return (32'(p) == CPUS - 1) ? '0 : p + 1'b1;
  endfunction

  rr_arbiter #(.N(CPUS)) u_darb (
    .req   (dREN | dWEN),
    .ptr   (dptr),
    .grant (dgrant_oh),
    .valid (dvalid)
  );

  rr_arbiter #(.N(CPUS)) u_iarb (
    .req   (iREN),
    .ptr   (iptr),
    .grant (igrant_oh),
    .valid (ivalid)
  );

  always_comb begin
    didx = '0;
    iidx = '0;
    for (int unsigned i = 0; i < CPUS; i++) begin
      if (dgrant_oh[GW'(i)]) didx = GW'(i);
      if (igrant_oh[GW'(i)]) iidx = GW'(i);
    end
  end

`ifdef BUS_COHERENCE_CTRL_SNOOP_EN
  logic [GW-1:0] snp, snp_n, flush_idx;
  logic          flush_hit;

  assign go_snoop = cctrans[didx];

  // Lowest-index snooper (excluding the requester) holding a write flushes.
  always_comb begin
    flush_hit = 1'b0;
    flush_idx = '0;
    for (int unsigned i = 0; i < CPUS; i++) begin
      if (!flush_hit && GW'(i) != gnt && dWEN[GW'(i)]) begin
        flush_hit = 1'b1;
        flush_idx = GW'(i);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) snp <= '0;
    else       snp <= snp_n;
  end
`else
  logic snoop_unused;
  assign go_snoop     = 1'b0;
  assign snoop_unused = ^{cctrans, ccwrite};
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      gnt   <= '0;
      dptr  <= '0;
      iptr  <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      dptr  <= dptr_n;
      iptr  <= iptr_n;
    end
  end

  always_comb begin
    state_n     = state;
    gnt_n       = gnt;
    dptr_n      = dptr;
    iptr_n      = iptr;
`ifdef BUS_COHERENCE_CTRL_SNOOP_EN
    snp_n       = snp;
`endif
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '1;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    case (state)
      IDLE: begin
        if (dvalid) begin
          gnt_n = didx;
          if (go_snoop)          state_n = SNOOP;
          else if (dWEN[didx])   state_n = RAMWR;
          else                   state_n = RAMRD;
        end else if (ivalid) begin
          gnt_n   = iidx;
          state_n = IFETCH;
        end
      end

`ifdef BUS_COHERENCE_CTRL_SNOOP_EN
      SNOOP, RESP: begin
        for (int unsigned i = 0; i < CPUS; i++) begin
          if (GW'(i) != gnt) begin
            ccwait[GW'(i)]      = 1'b1;
            ccinv[GW'(i)]       = ccwrite[gnt];
            ccsnoopaddr[GW'(i)] = daddr[gnt];
          end
        end
        if (!(dREN[gnt] || dWEN[gnt])) state_n = IDLE;
        else if (state == SNOOP)       state_n = RESP;
        else if (flush_hit) begin
          snp_n   = flush_idx;
          state_n = C2C;
        end else if (dWEN[gnt])        state_n = RAMWR;
        else                           state_n = RAMRD;
      end

      C2C: begin
        if (!(dREN[gnt] || dWEN[gnt]) || !dWEN[snp]) state_n = IDLE;
        else begin
          ramWEN     = 1'b1;
          ramaddr    = RAM_AW'(daddr[snp]);
          ramstore   = dstore[snp];
          dload[gnt] = dstore[snp];
          if (ram_st == ACCESS) begin
            dwait[gnt] = 1'b0;
            dwait[snp] = 1'b0;
            dptr_n     = ptr_inc(gnt);
            state_n    = IDLE;
          end
        end
      end
`endif

      RAMRD: begin
        if (!dREN[gnt]) state_n = IDLE;
        else begin
          ramREN     = 1'b1;
          ramaddr    = RAM_AW'(daddr[gnt]);
          dload[gnt] = ram_rdata;
          if (ram_st == ACCESS) begin
            dwait[gnt] = 1'b0;
            dptr_n     = ptr_inc(gnt);
            state_n    = IDLE;
          end
        end
      end

      RAMWR: begin
        if (!dWEN[gnt]) state_n = IDLE;
        else begin
          ramWEN   = 1'b1;
          ramaddr  = RAM_AW'(daddr[gnt]);
          ramstore = dstore[gnt];
          if (ram_st == ACCESS) begin
            dwait[gnt] = 1'b0;
            dptr_n     = ptr_inc(gnt);
            state_n    = IDLE;
          end
        end
      end

      IFETCH: begin
        if (!iREN[gnt]) state_n = IDLE;
        else begin
          ramREN     = 1'b1;
          ramaddr    = RAM_AW'(iaddr[gnt]);
          iload[gnt] = ram_rdata;
          if (ram_st == ACCESS) begin
            iwait[gnt] = 1'b0;
            iptr_n     = ptr_inc(gnt);
            state_n    = IDLE;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/bus_coherence_ctrl.md
BUS_COHERENCE_CTRL -- requirements
Module: bus_coherence_ctrl

Interface
REQ-001 Parameter: CPUS, default 4, number of cache/CPU channels (2..8).
REQ-002 Parameter: RAM_AW, default 32, RAM address width.
REQ-003 CLK  in  1  clock, rising edge.
REQ-004 nRST  in  1  asynchronous, active-low reset.
REQ-005 iREN, dREN, dWEN  in  CPUS  per-CPU instruction read, data read and data write requests.
REQ-006 iaddr, daddr, dstore  in  CPUS x 32  per-CPU instruction address, data address and write data.
REQ-007 cctrans, ccwrite  in  CPUS  per-CPU coherence transaction flag and exclusive-intent (RdX) flag.
REQ-008 iwait, dwait  out  CPUS  per-CPU stall; 0 = transfer completes this cycle.
REQ-009 iload, dload  out  CPUS x 32  per-CPU read data.
REQ-010 ccwait, ccinv  out  CPUS  per-CPU snoop-hold and invalidate strobes.
REQ-011 ccsnoopaddr  out  CPUS x 32  per-CPU snoop address; 32'hFFFFFFFF when not snooped.
REQ-012 ramREN, ramWEN  out  1  RAM read and write enables.
REQ-013 ramaddr, ramstore  out  RAM_AW / 32  RAM address and write data.
REQ-014 ramload  in  32  RAM read data.
REQ-015 ramstate  in  2  RAM status: FREE, BUSY, ACCESS, ERROR.

Function
REQ-016 FSM states SHALL be IDLE, SNOOP, RESP, C2C, RAMRD, RAMWR, IFETCH.
REQ-017 IDLE SHALL grant by round-robin over data requesters (dREN|dWEN), starting at data pointer dptr; if none, over iREN, starting at iptr; grant is registered, with transition next cycle.
REQ-018 Data requests SHALL beat instruction requests; same-CPU simultaneous iREN and dREN: data first.
REQ-019 Granted data request with cctrans=1 -> SNOOP; with cctrans=0 -> RAMRD (dREN) or RAMWR (dWEN); instruction grant -> IFETCH.
REQ-020 SNOOP (1 cycle): for every CPU other than granted g: ccwait=1, ccsnoopaddr=daddr[g], ccinv=ccwrite[g]; next state RESP.
REQ-021 RESP: snoop outputs held; lowest-index snooper s with dWEN[s]=1 (flush) -> C2C; none -> RAMRD or RAMWR for g.
REQ-022 C2C: dload[g]=dstore[s]; ramWEN=1, ramaddr=daddr[s], ramstore=dstore[s]; on ramstate==ACCESS both dwait[g] and dwait[s] = 0 in that cycle; then IDLE.
REQ-023 RAMRD/RAMWR/IFETCH: drive RAM from granted channel; matching wait = 0 only in the cycle ramstate==ACCESS; then IDLE.
REQ-024 All non-granted waits SHALL be 1; ramstate BUSY, FREE or ERROR SHALL hold all waits at 1.
REQ-025 Granted request dropped before ACCESS: return to IDLE next cycle, pointer not advanced.
REQ-026 On completion, the serviced pointer SHALL become (granted+1) mod CPUS.
REQ-027 At most one RAM enable SHALL be asserted in any cycle.

Reset
REQ-028 nRST low: state IDLE, dptr=iptr=0, grant registers 0; outputs: waits 1, loads 0, ram enables 0, ramaddr/ramstore 0, ccwait/ccinv 0, ccsnoopaddr all-ones.
REQ-029 Reset mid-transaction SHALL abort it with no partial completion signalled.

Configuration
REQ-030 Macro BUS_COHERENCE_CTRL_SNOOP_EN defined: REQ-019..022 active.
REQ-031 Undefined: cctrans ignored, SNOOP/RESP/C2C unreachable, ccwait/ccinv held 0, ccsnoopaddr held all-ones; pure round-robin RAM arbiter.

Structure
REQ-032 word_t and ramstate_t SHALL come from cpu_types_pkg; mc_state_t enum and CPUS_MAX=8 SHALL be added there.
REQ-033 Round-robin selection SHALL be sub-module rr_arbiter (params N; req, ptr in; grant one-hot, valid out), instantiated twice.

Verification
REQ-034 CPUS=4, dREN[1]&dREN[3] together, ACCESS each 2nd cycle -> CPU1 served first, CPU3 next; dptr=0 after.
REQ-035 iREN[0] and dREN[2] same cycle -> RAMRD for CPU2 first, then IFETCH for CPU0; iload[0]=ramload when iwait[0]=0.
REQ-036 CPU0 cctrans=1, ccwrite=1, daddr=0x100; CPU2 flushes dstore=0xDEADBEEF -> ccinv=1 on CPUs 1-3; dload[0]=0xDEADBEEF, RAM write 0x100, dwait[0]=dwait[2]=0 same cycle.
REQ-037 Snoop with no flush -> RAMRD for requester; ccsnoopaddr returns to all-ones in IDLE.
REQ-038 nRST pulsed during RAMWR with ramstate BUSY -> all waits 1, ramWEN 0, IDLE next cycle.
REQ-039 Build without BUS_COHERENCE_CTRL_SNOOP_EN, cctrans=1 -> direct RAMRD, ccwait never asserted.
